dffn_chain_exerciser: RTL and testbench



---
 rtl/dffn_chain_exerciser.sv | 200 ++++++++++++++++++++
 tb/tb_dffn_chain_exerciser.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dffn_chain_exerciser.sv
// PRBS7 pattern transmitter/checker for a serial chain of negative-edge, active-low-reset flops.
// Optional macro DFFN_CHAIN_EXERCISER_ERR_INJECT_EN adds the INJ port for deliberate bit flips.
module dffn_chain_exerciser #(
   parameter int unsigned CHAIN_LEN = 8,
   parameter int unsigned NUM_BITS  = 127
) (
   input  logic       CLK,
   input  logic       R,
   input  logic       START,
`ifdef DFFN_CHAIN_EXERCISER_ERR_INJECT_EN
   input  logic       INJ,
`endif
   input  logic       DUT_Q,
   output logic       DUT_D,
   output logic       DUT_CLKN,
   output logic       DUT_RN,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [7:0] ERR_CNT
);

   localparam int unsigned HistW = (CHAIN_LEN > 1) ? CHAIN_LEN - 1 : 1;
   localparam logic [15:0] LastBit   = 16'(NUM_BITS - 1);
   localparam logic [15:0] LastDrain = 16'(CHAIN_LEN - 2);
   localparam logic [6:0]  Seed      = 7'h7F;

   typedef enum logic [2:0] {StIdle, StRstp, StRun, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [1:0]       ph_q, ph_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [6:0]       lfsr_q, lfsr_d;
   logic [HistW-1:0] hist_q, hist_d;
   logic             tx_q, tx_d;
   logic [7:0]       err_q, err_d;
   logic             d_q, d_d;
   logic             clkn_q, clkn_d;
   logic             rn_q, rn_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   logic [6:0]       lfsr_next;
   logic [HistW-1:0] hist_shift;
   logic [7:0]       err_inc;
   logic             exp_bit;
   logic             run_bit;

   assign lfsr_next  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
   // tx_q holds the uninverted bit of the current DUT-cycle; the history trails it by one.
   assign hist_shift = HistW'({hist_q, tx_q});
   assign err_inc    = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
   assign exp_bit    = (CHAIN_LEN == 1) ? tx_q : hist_q[HistW-1];

`ifdef DFFN_CHAIN_EXERCISER_ERR_INJECT_EN
   assign run_bit = lfsr_q[6] ^ INJ;
`else
   assign run_bit = lfsr_q[6];
`endif

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      hist_d  = hist_q;
      tx_d    = tx_q;
      err_d   = err_q;
      d_d     = d_q;
      rn_d    = rn_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (START) begin
               state_d = StRstp;
               ph_d    = 2'd0;
               cnt_d   = 16'd0;
               lfsr_d  = Seed;
               hist_d  = '0;
               tx_d    = 1'b0;
               err_d   = 8'd0;
               d_d     = 1'b0;
               rn_d    = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end

         StRstp: begin
            // ph_q counts the four reset-pulse cycles here.
            ph_d = ph_q + 2'd1;
            if (ph_q == 2'd3) begin
               if (DUT_Q) err_d = err_inc;
               state_d = StRun;
               cnt_d   = 16'd0;
               rn_d    = 1'b1;
               d_d     = run_bit;
               tx_d    = lfsr_q[6];
               lfsr_d  = lfsr_next;
               hist_d  = hist_shift;
            end
         end

         StRun: begin
            ph_d = ph_q + 2'd1;
            if (ph_q == 2'd3) begin
               if (DUT_Q != exp_bit) err_d = err_inc;
               if (cnt_q != LastBit) begin
                  cnt_d  = cnt_q + 16'd1;
                  d_d    = run_bit;
                  tx_d   = lfsr_q[6];
                  lfsr_d = lfsr_next;
                  hist_d = hist_shift;
               end else if (CHAIN_LEN > 1) begin
                  state_d = StDrain;
                  cnt_d   = 16'd0;
                  d_d     = 1'b0;
                  tx_d    = 1'b0;
                  hist_d  = hist_shift;
               end else begin
                  state_d = StDone;
                  d_d     = 1'b0;
                  rn_d    = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 8'd0);
               end
            end
         end

         StDrain: begin
            ph_d = ph_q + 2'd1;
            if (ph_q == 2'd3) begin
               if (DUT_Q != exp_bit) err_d = err_inc;
               if (cnt_q != LastDrain) begin
                  cnt_d  = cnt_q + 16'd1;
                  hist_d = hist_shift;
               end else begin
                  state_d = StDone;
                  rn_d    = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 8'd0);
               end
            end
         end

         default: state_d = StIdle;
      endcase

      // Chain clock low in ph2/ph3 only; falling edge lands mid DUT-cycle.
      clkn_d = ~(((state_d == StRun) || (state_d == StDrain)) && ph_d[1]);
   end

   always_ff @(posedge CLK or posedge R) begin
      if (R) begin
         state_q <= StIdle;
         ph_q    <= 2'd0;
         cnt_q   <= 16'd0;
         lfsr_q  <= Seed;
         hist_q  <= '0;
         tx_q    <= 1'b0;
         err_q   <= 8'd0;
         d_q     <= 1'b0;
         clkn_q  <= 1'b1;
         rn_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         hist_q  <= hist_d;
         tx_q    <= tx_d;
         err_q   <= err_d;
         d_q     <= d_d;
         clkn_q  <= clkn_d;
         rn_q    <= rn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign DUT_D    = d_q;
   assign DUT_CLKN = clkn_q;
   assign DUT_RN   = rn_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign PASS     = pass_q;
   assign ERR_CNT  = err_q;

endmodule

// File: tb/tb_dffn_chain_exerciser.sv
// Directed bench for dffn_chain_exerciser with a behavioural flop-chain model.
// Chain modes: 0 ideal 8 flops, 1 stage 3 stuck-at-0, 2 one flop short.
module tb_dffn_chain_exerciser;
   localparam int Budget = 6000;

   logic       clk = 1'b0;
   logic       r = 1'b1;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   logic       dut_q, dut_d, dut_clkn, dut_rn, busy, done, pass;
   logic [7:0] err_cnt;
   logic       d2, clkn2, rn2, busy2, done2, pass2;
   logic [7:0] err2;
`ifdef DFFN_CHAIN_EXERCISER_ERR_INJECT_EN
   logic       inj = 1'b0;
`endif
   int         errors = 0;
   int         checks = 0;
   int         mode = 0;
   logic [7:0] chain;

   always #5 clk = ~clk;

   // Negative-edge flop chain with active-low async reset.
   always @(negedge dut_clkn or negedge dut_rn) begin
      if (!dut_rn) chain <= '0;
      else chain <= {chain[6:3], (mode == 1) ? 1'b0 : chain[2], chain[1:0], dut_d};
   end

   always_comb begin
      dut_q = chain[7];
      if (mode == 2) dut_q = chain[6];
   end

   dffn_chain_exerciser #(.CHAIN_LEN(8), .NUM_BITS(127)) u_dut (
      .CLK(clk), .R(r), .START(start),
`ifdef DFFN_CHAIN_EXERCISER_ERR_INJECT_EN
      .INJ(inj),
`endif
      .DUT_Q(dut_q), .DUT_D(dut_d), .DUT_CLKN(dut_clkn), .DUT_RN(dut_rn),
      .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt)
   );

   // Stuck-at-1 chain with a long run for saturation.
   dffn_chain_exerciser #(.CHAIN_LEN(8), .NUM_BITS(1000)) u_sat (
      .CLK(clk), .R(r), .START(start2),
`ifdef DFFN_CHAIN_EXERCISER_ERR_INJECT_EN
      .INJ(1'b0),
`endif
      .DUT_Q(1'b1), .DUT_D(d2), .DUT_CLKN(clkn2), .DUT_RN(rn2),
      .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(err2)
   );

   task automatic start_run();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < Budget) begin @(posedge clk); #1; cyc++; end
   endtask

   task automatic test_reset();
      r = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (dut_d !== 1'b0) begin errors++; $display("FAIL rst_d: got %b want 0", dut_d); end
      checks++; if (dut_clkn !== 1'b1) begin errors++; $display("FAIL rst_clkn: got %b want 1", dut_clkn); end
      checks++; if (dut_rn !== 1'b0) begin errors++; $display("FAIL rst_rn: got %b want 0", dut_rn); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL rst_pass: got %b want 0", pass); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err: got %0d want 0", err_cnt); end
      checks++; if (clkn2 !== 1'b1 || rn2 !== 1'b0 || d2 !== 1'b0) begin
         errors++; $display("FAIL rst_sat_pins: got clkn=%b rn=%b d=%b want 1 0 0", clkn2, rn2, d2);
      end
      @(negedge clk); r = 1'b0;
   endtask

   task automatic test_ideal();
      int cyc, first, ncap;
      logic [7:0] txcap;
      mode = 0;
      start_run();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ideal_busy: got %b want 1", busy); end
      cyc = 0; first = -1; ncap = 0; txcap = '0;
      while (done !== 1'b1 && cyc < Budget) begin
         @(posedge clk); #1; cyc++;
         if (cyc >= 4 && (cyc - 4) % 4 == 0 && ncap < 8) begin
            txcap = {txcap[6:0], dut_d}; ncap++;
         end
         if (cyc == 4) begin
            checks++; if (dut_rn !== 1'b1 || dut_clkn !== 1'b1) begin
               errors++; $display("FAIL ideal_run_entry: got rn=%b clkn=%b want 1 1", dut_rn, dut_clkn);
            end
         end
         if (cyc == 6) begin
            checks++; if (dut_clkn !== 1'b0) begin
               errors++; $display("FAIL ideal_fall: got clkn=%b want 0", dut_clkn);
            end
         end
         if (dut_q === 1'b1 && first < 0) first = (cyc - 4) / 4;
      end
      checks++; if (cyc != 540) begin errors++; $display("FAIL ideal_len: got %0d want 540", cyc); end
      checks++; if (txcap !== 8'hFE) begin errors++; $display("FAIL ideal_prbs: got %h want fe", txcap); end
      checks++; if (first != 7) begin errors++; $display("FAIL ideal_first_q: got %0d want 7", first); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL ideal_err: got %0d want 0", err_cnt); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ideal_pass: got %b want 1", pass); end
   endtask

   task automatic test_stuck0();
      int cyc;
      mode = 1;
      start_run();
      wait_done(cyc);
      checks++; if (cyc != 540) begin errors++; $display("FAIL stuck0_len: got %0d want 540", cyc); end
      checks++; if (err_cnt !== 8'd64) begin errors++; $display("FAIL stuck0_err: got %0d want 64", err_cnt); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck0_pass: got %b want 0", pass); end
   endtask

   task automatic test_short();
      int cyc;
      mode = 2;
      start_run();
      wait_done(cyc);
      checks++; if (err_cnt === 8'd0) begin errors++; $display("FAIL short_err: got 0 want nonzero"); end
      checks++; if (pass !== 1'b0 || done !== 1'b1) begin
         errors++; $display("FAIL short_pass: got pass=%b done=%b want 0 1", pass, done);
      end
   endtask

   task automatic test_saturate();
      int cyc;
      @(negedge clk); start2 = 1'b1;
      @(posedge clk); #1; start2 = 1'b0;
      cyc = 0;
      while (done2 !== 1'b1 && cyc < Budget) begin @(posedge clk); #1; cyc++; end
      checks++; if (cyc != 4032) begin errors++; $display("FAIL sat_len: got %0d want 4032", cyc); end
      checks++; if (err2 !== 8'd255) begin errors++; $display("FAIL sat_err: got %0d want 255", err2); end
      checks++; if (pass2 !== 1'b0 || busy2 !== 1'b0) begin
         errors++; $display("FAIL sat_pass: got pass=%b busy=%b want 0 0", pass2, busy2);
      end
   endtask

   task automatic test_abort();
      int cyc;
      mode = 2;
      start_run();
      wait_cycles(86);
      checks++; if (dut_clkn !== 1'b0 || err_cnt === 8'd0) begin
         errors++; $display("FAIL abort_pre: got clkn=%b err=%0d want 0 nonzero", dut_clkn, err_cnt);
      end
      @(negedge clk); r = 1'b1;
      @(posedge clk); #1;
      checks++; if (dut_rn !== 1'b0) begin errors++; $display("FAIL abort_rn: got %b want 0", dut_rn); end
      checks++; if (dut_clkn !== 1'b1) begin errors++; $display("FAIL abort_clkn: got %b want 1", dut_clkn); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL abort_err: got %0d want 0", err_cnt); end
      @(negedge clk); r = 1'b0;
      mode = 0;
      start_run();
      wait_done(cyc);
      checks++; if (cyc != 540) begin errors++; $display("FAIL abort_rerun_len: got %0d want 540", cyc); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL abort_rerun_pass: got %b want 1", pass); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      mode = 1;
      start_run();
      wait_done(cyc);
      mode = 0;
      start_run();
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL b2b_restart: got done=%b busy=%b want 0 1", done, busy);
      end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL b2b_err_clr: got %0d want 0", err_cnt); end
      wait_cycles(99);
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_done(cyc);
      checks++; if (cyc + 100 != 540) begin
         errors++; $display("FAIL b2b_ignored_len: got %0d want 540", cyc + 100);
      end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL b2b_pass: got %b want 1", pass); end
      start_run();
      checks++; if (pass !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL b2b_pass_clr: got pass=%b done=%b want 0 0", pass, done);
      end
      wait_done(cyc);
      checks++; if (cyc != 540 || pass !== 1'b1) begin
         errors++; $display("FAIL b2b_second: got len=%0d pass=%b want 540 1", cyc, pass);
      end
   endtask

`ifdef DFFN_CHAIN_EXERCISER_ERR_INJECT_EN
   task automatic test_inject();
      int cyc;
      mode = 0;
      start_run();
      cyc = 0;
      while (done !== 1'b1 && cyc < Budget) begin
         // High across the edge that enters ph0 of RUN DUT-cycles 10, 30, 50.
         inj = (cyc + 1 == 44 || cyc + 1 == 124 || cyc + 1 == 204) ? 1'b1 : 1'b0;
         @(posedge clk); #1; cyc++;
      end
      inj = 1'b0;
      checks++; if (cyc != 540) begin errors++; $display("FAIL inj_len: got %0d want 540", cyc); end
      checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL inj_err: got %0d want 3", err_cnt); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL inj_pass: got %b want 0", pass); end
   endtask
`endif

   initial begin
      test_reset();
      test_ideal();
      test_stuck0();
      test_short();
      test_saturate();
      test_abort();
      test_back_to_back();
`ifdef DFFN_CHAIN_EXERCISER_ERR_INJECT_EN
      test_inject();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
